// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Moore control FSM for a multicycle MIPS datapath (PC, IR, register file, ALU,
// unified memory). It decodes the IR opcode/funct fields and drives the
// per-state enables and mux selects. It also counts retired instructions and
// traps on unsupported encodings.
//
// Optional feature macro: MCTL_MEMWAIT_EN
//   defined   : FETCH, MEM_RD and MEM_WR stall until mem_ready=1
//   undefined : mem_ready is ignored and every memory state takes one cycle
//
// Ports
//   CLK         in   clock; all state changes on the rising edge
//   RST         in   synchronous active-high reset
//   opcode      in   IR[31:26]
//   funct       in   IR[5:0]
//   zero        in   ALU zero flag, sampled in BRANCH
//   mem_ready   in   memory access complete (MCTL_MEMWAIT_EN builds only)
//   pc_we       out  PC write
//   pc_src      out  0 ALU result, 1 ALUOut (branch target), 2 jump target
//   iord        out  memory address select: 0 PC, 1 ALUOut
//   mem_re      out  memory read
//   mem_we      out  memory write
//   ir_we       out  IR load
//   reg_we      out  register file write
//   reg_dst     out  0 rt, 1 rd
//   mem_to_reg  out  0 ALUOut, 1 MDR
//   alu_src_a   out  0 PC, 1 A
//   alu_src_b   out  0 B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2
//   alu_op      out  0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT
//   illegal     out  high while in TRAP
//   state       out  current state encoding (debug)
//   inst_count  out  retired-instruction counter, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_R   = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    TRAP   = 4'd11
  } state_e;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_NOR = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  // Memory handshake: a memory state (FETCH, MEM_RD, MEM_WR) presents its
  // request and holds every output steady while mem_ok is low; the access
  // completes in the cycle mem_ok is high, which is also the only cycle in
  // which the architectural write enables of FETCH (pc_we, ir_we) pulse.
  logic mem_ok;
`ifdef MCTL_MEMWAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // R-type function decode: legality and ALU operation.
  logic       r_legal;
  logic [2:0] r_alu;
  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case (funct)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h26:   r_alu = ALU_XOR;
      6'h27:   r_alu = ALU_NOR;
      6'h2A:   r_alu = ALU_SLT;
      default: r_legal = 1'b0;
    endcase
  end

  // Immediate ALU operation from the opcode (only consulted in EXEC_I).
  logic [2:0] i_alu;
  always_comb begin
    i_alu = ALU_ADD;
    case (opcode)
      6'h0C:   i_alu = ALU_AND;
      6'h0D:   i_alu = ALU_OR;
      6'h0A:   i_alu = ALU_SLT;
      default: i_alu = ALU_ADD;
    endcase
  end

  // Next-state and Moore outputs. The IR is only reloaded in FETCH, so
  // opcode/funct are stable throughout DECODE..retire and may shape outputs.
  always_comb begin
    state_d    = FETCH;
    retire     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALU_AND;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADD;
        ir_we     = mem_ok;
        pc_we     = mem_ok;
        state_d   = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        case (opcode)
          6'h00:                      state_d = r_legal ? EXEC_R : TRAP;
          6'h08, 6'h0C, 6'h0D, 6'h0A: state_d = EXEC_I;
          6'h23, 6'h2B:               state_d = ADDR;
          6'h04, 6'h05:               state_d = BRANCH;
          6'h02:                      state_d = JUMP;
          default:                    state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu;
        state_d   = WB_R;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = i_alu;
        state_d   = WB_R;
      end
      WB_R: begin
        reg_we  = 1'b1;
        reg_dst = (opcode == 6'h00);
        retire  = 1'b1;
        state_d = FETCH;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
        state_d   = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        iord    = 1'b1;
        mem_re  = 1'b1;
        state_d = mem_ok ? WB_MEM : MEM_RD;
      end
      WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        iord    = 1'b1;
        mem_we  = 1'b1;
        retire  = mem_ok;
        state_d = mem_ok ? FETCH : MEM_WR;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'd1;
        pc_we     = (opcode == 6'h05) ? ~zero : zero;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_src  = 2'd2;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP;
      end
      default: state_d = FETCH;
    endcase

    // Reset suppresses every architectural write in the cycle it is held.
    if (RST) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      mem_we = 1'b0;
      reg_we = 1'b0;
    end
  end

  assign count_d = count_q + CNT_W'(retire);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state      = state_q;
  assign inst_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int CW    = 17;
  localparam int W     = 4 + CW + CNT_W;

`ifdef MCTL_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_R   = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;

  // ---------------- clock / reset / DUT ----------------
  logic             CLK = 1'b0;
  logic             RST;
  logic [5:0]       opcode, funct;
  logic             zero, mem_ready;
  logic             pc_we, iord, mem_re, mem_we, ir_we, reg_we, reg_dst;
  logic             mem_to_reg, alu_src_a, illegal;
  logic [1:0]       pc_src, alu_src_b;
  logic [2:0]       alu_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] inst_count;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .iord(iord),
    .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .state(state), .inst_count(inst_count)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]     exp_q[$];
  int               vectors     = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] m_count;

  // ---------------- reference model ----------------
  // Instruction classes: 0 R-ALU, 1 I-ALU, 2 lw, 3 sw, 4 branch, 5 j, 6 illegal
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) ? 0 : 6;
      6'h08, 6'h0C, 6'h0D, 6'h0A: return 1;
      6'h23: return 2;
      6'h2B: return 3;
      6'h04, 6'h05: return 4;
      6'h02: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'h22: return 3'd6;
      6'h24: return 3'd0;
      6'h25: return 3'd1;
      6'h26: return 3'd3;
      6'h27: return 3'd4;
      6'h2A: return 3'd7;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [2:0] alu_of_opcode(input logic [5:0] op);
    case (op)
      6'h0C: return 3'd0;
      6'h0D: return 3'd1;
      6'h0A: return 3'd7;
      default: return 3'd2;
    endcase
  endfunction

  // Expected control word for one cycle in state st.
  function automatic logic [CW-1:0] ctrl(input logic [3:0] st, input logic [5:0] op,
                                         input logic [5:0] fn, input logic z,
                                         input logic rdy, input logic rst);
    logic       p_we, i_or, m_re, m_we, i_we, r_we, r_dst, m2r, sa, ill;
    logic [1:0] p_src, sb;
    logic [2:0] aop;
    {p_we, i_or, m_re, m_we, i_we, r_we, r_dst, m2r, sa, ill} = '0;
    p_src = 2'd0; sb = 2'd0; aop = 3'd0;
    case (st)
      S_FETCH:  begin m_re = 1; i_we = rdy; p_we = rdy; sb = 2'd1; aop = 3'd2; end
      S_DECODE: begin sb = 2'd3; aop = 3'd2; end
      S_EXEC_R: begin sa = 1; aop = alu_of_funct(fn); end
      S_EXEC_I: begin sa = 1; sb = 2'd2; aop = alu_of_opcode(op); end
      S_WB_R:   begin r_we = 1; r_dst = (op == 6'h00); end
      S_ADDR:   begin sa = 1; sb = 2'd2; aop = 3'd2; end
      S_MEM_RD: begin i_or = 1; m_re = 1; end
      S_WB_MEM: begin r_we = 1; m2r = 1; end
      S_MEM_WR: begin i_or = 1; m_we = 1; end
      S_BRANCH: begin sa = 1; aop = 3'd6; p_src = 2'd1; p_we = (op == 6'h04) ? z : ~z; end
      S_JUMP:   begin p_src = 2'd2; p_we = 1; end
      S_TRAP:   ill = 1;
      default: ;
    endcase
    if (rst) begin p_we = 0; i_we = 0; m_we = 0; r_we = 0; end
    return {p_we, p_src, i_or, m_re, m_we, i_we, r_we, r_dst, m2r, sa, sb, aop, ill};
  endfunction

  function automatic bit is_mem_state(input logic [3:0] st);
    return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  endfunction

  // ---------------- driver ----------------
  // Runs one instruction. rst_at: cycle index to hold RST (-1 none).
  // lows: exact low mem_ready cycles in MEM_RD/MEM_WR (-1 random).
  // zf: forced zero flag (-1 random).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int rst_at, input int lows, input int zf);
    logic [3:0] seq[$];
    int         kind, cyc, low_seen, t;
    logic       rdy, eff, rst_now;
    kind = classify(op, fn);
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (kind)
      0: begin seq.push_back(S_EXEC_R); seq.push_back(S_WB_R); end
      1: begin seq.push_back(S_EXEC_I); seq.push_back(S_WB_R); end
      2: begin seq.push_back(S_ADDR); seq.push_back(S_MEM_RD); seq.push_back(S_WB_MEM); end
      3: begin seq.push_back(S_ADDR); seq.push_back(S_MEM_WR); end
      4: seq.push_back(S_BRANCH);
      5: seq.push_back(S_JUMP);
      default: ;
    endcase
    opcode = op;
    funct  = fn;
    cyc    = 0;
    for (int i = 0; i < seq.size(); i++) begin
      low_seen = 0;
      forever begin
        if (lows >= 0)
          rdy = (seq[i] == S_FETCH) ? 1'b1 : (low_seen >= lows);
        else
          rdy = ($urandom_range(0, 2) != 0) || (low_seen >= 3);
        mem_ready = rdy;
        zero      = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
        eff       = (MEMWAIT && is_mem_state(seq[i])) ? rdy : 1'b1;
        rst_now   = (cyc == rst_at);
        RST       = rst_now;
        exp_q.push_back({seq[i], ctrl(seq[i], op, fn, zero, eff, rst_now), m_count});
        @(posedge CLK); #1;
        cyc++;
        if (rst_now) begin
          RST     = 1'b0;
          m_count = '0;
          return;
        end
        if (eff) break;
        low_seen++;
      end
      if (i == seq.size() - 1 && kind != 6) m_count = m_count + 1'b1;
    end
    if (kind == 6) begin
      // Ten trapped cycles, then a reset cycle (still in TRAP) to escape.
      for (t = 0; t <= 10; t++) begin
        mem_ready = 1'($urandom_range(0, 1));
        zero      = 1'($urandom_range(0, 1));
        rst_now   = (t == 10) || (cyc == rst_at);
        RST       = rst_now;
        exp_q.push_back({S_TRAP, ctrl(S_TRAP, op, fn, zero, 1'b1, rst_now), m_count});
        @(posedge CLK); #1;
        cyc++;
        if (rst_now) begin
          RST     = 1'b0;
          m_count = '0;
          return;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {state, pc_we, pc_src, iord, mem_re, mem_we, ir_we, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, inst_count};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL ctrl_word t=%0t state act=%0d exp=%0d word act=%h exp=%h",
                 $time, state, exp_v[W-1 -: 4], act_v, exp_v);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ops[10];
    logic [5:0] fns[7];
    logic [5:0] op, fn;
    int         rst_at;
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

    RST = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    m_count = '0;
    @(posedge CLK); #1;
    // Reset state: FETCH, count 0, write enables suppressed.
    mem_ready = 1'b1;
    exp_q.push_back({S_FETCH, ctrl(S_FETCH, 6'h00, 6'h00, 1'b0, 1'b1, 1'b1), CNT_W'(0)});
    @(posedge CLK); #1;
    RST = 1'b0;

    run_instr(6'h00, 6'h20, 1, -1, -1);   // reset while in DECODE
    run_instr(6'h00, 6'h20, -1, -1, -1);  // add
    run_instr(6'h23, 6'h00, -1, 3, -1);   // lw with 3 wait cycles in MEM_RD
    run_instr(6'h2B, 6'h00, -1, 2, -1);   // sw with waits
    run_instr(6'h04, 6'h00, -1, -1, 1);   // beq taken
    run_instr(6'h05, 6'h00, -1, -1, 1);   // bne not taken
    run_instr(6'h04, 6'h00, -1, -1, 0);
    run_instr(6'h05, 6'h00, -1, -1, 0);
    run_instr(6'h00, 6'h30, -1, -1, -1);  // illegal funct
    run_instr(6'h3F, 6'h00, -1, -1, -1);  // illegal opcode
    run_instr(6'h00, 6'h20, 3, -1, -1);   // reset in WB_R
    for (int i = 0; i < 17; i++) run_instr(6'h02, 6'h00, -1, 0, -1);  // counter wrap

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 11) < 10) op = ops[$urandom_range(0, 9)];
      else                            op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0)  fn = 6'($urandom_range(0, 63));
      else                            fn = fns[$urandom_range(0, 6)];
      rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, fn, rst_at, -1, -1);
    end

    repeat (2) @(posedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog expired at t=%0t required completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
